// File: rtl/digit_score_renderer.sv
// Seven-segment numeric sprite generator: serial binary-to-BCD conversion,
// frame-synchronous digit commit and a two-stage pixel rendering pipeline.
module digit_score_renderer #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned VAL_W       = 14,
   parameter int unsigned COLOR_W     = 10,
   parameter int unsigned ORIGIN_X    = 0,
   parameter int unsigned ORIGIN_Y    = 0,
   parameter int unsigned DIGIT_PITCH = 32,
   parameter int unsigned FG_COLOR    = 430,
   parameter int unsigned BG_COLOR    = 391,
   parameter int unsigned LEAD_BLANK  = 1,
   parameter int unsigned FRAME_SYNC  = 1
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [VAL_W-1:0]   value,
   input  logic               value_valid,
   output logic               value_ready,
   input  logic               frame_start,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   output logic               pixel_on,
   output logic [COLOR_W-1:0] pixel_color
);

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int unsigned LIMIT = pow10(NUM_DIGITS);
   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(VAL_W + 1);
   localparam int unsigned K_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CONVERT    = 2'd1,
      WAIT_FRAME = 2'd2,
      COMMIT     = 2'd3
   } state_t;

   state_t                        state;
   logic [VAL_W-1:0]              bin;
   logic [BCD_W-1:0]              bcd;
   logic [BCD_W-1:0]              bcd_adj;
   logic [CNT_W-1:0]              cnt;
   logic [VAL_W-1:0]              value_sat;
   logic [NUM_DIGITS-1:0][3:0]    disp;
   logic [NUM_DIGITS-1:0]         blank;

   logic [10:0]                   dx;
   logic [10:0]                   dy;
   int unsigned                   kq;
   int unsigned                   colq;
   logic                          hit;

   logic                          s1_hit;
   logic [K_W-1:0]                s1_k;
   logic [4:0]                    s1_col;
   logic [4:0]                    s1_row;
   logic                          lit;

   // Clamp out-of-range inputs to the largest displayable value
   always_comb begin
      value_sat = value;
      if (32'(value) >= LIMIT) value_sat = VAL_W'(LIMIT - 1);
   end

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Load / convert / wait-for-frame / commit controller and display registers
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state       <= IDLE;
         value_ready <= 1'b1;
         bin         <= '0;
         bcd         <= '0;
         cnt         <= '0;
         disp        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (value_valid) begin
                  bin         <= value_sat;
                  bcd         <= '0;
                  cnt         <= '0;
                  value_ready <= 1'b0;
                  state       <= CONVERT;
               end
            end
            CONVERT: begin
               bcd <= BCD_W'({bcd_adj, bin[VAL_W-1]});
               bin <= {bin[VAL_W-2:0], 1'b0};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(VAL_W - 1)) state <= (FRAME_SYNC != 0) ? WAIT_FRAME : COMMIT;
            end
            WAIT_FRAME: begin
               if (frame_start) state <= COMMIT;
            end
            COMMIT: begin
               for (int i = 0; i < int'(NUM_DIGITS); i++)
                  disp[i] <= bcd[4*(int'(NUM_DIGITS)-1-i) +: 4];
               value_ready <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Leading-zero suppression: blank while every digit from the left is zero
   always_comb begin
      logic zrun;
      zrun  = 1'b1;
      blank = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         zrun     = zrun & (disp[i] == 4'd0);
         blank[i] = (LEAD_BLANK != 0) && (i < int'(NUM_DIGITS) - 1) && zrun;
      end
   end

   // Cell geometry: borrow out of the subtraction marks a pixel left/above the origin
   always_comb begin
      dx   = {1'b0, DrawX} - 11'(ORIGIN_X);
      dy   = {1'b0, DrawY} - 11'(ORIGIN_Y);
      kq   = 32'(dx[9:0]) / DIGIT_PITCH;
      colq = 32'(dx[9:0]) % DIGIT_PITCH;
      hit  = !dx[10] && !dy[10] && (kq < NUM_DIGITS) && (colq < 32) && (32'(dy[9:0]) < 24);
   end

   // Pixel stage 1: register hit flag and cell-local coordinates
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         s1_hit <= 1'b0;
         s1_k   <= '0;
         s1_col <= '0;
         s1_row <= '0;
      end else begin
         s1_hit <= hit;
         s1_k   <= K_W'(kq);
         s1_col <= 5'(colq);
         s1_row <= 5'(dy[9:0]);
      end
   end

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic in_box(input logic [4:0] r, input logic [4:0] c,
                                   input int unsigned r0, input int unsigned r1,
                                   input int unsigned c0, input int unsigned c1);
      return (32'(r) >= r0) && (32'(r) <= r1) && (32'(c) >= c0) && (32'(c) <= c1);
   endfunction

   // Bit order {a,b,c,d,e,f,g}: which segment rectangles contain this cell pixel
   function automatic logic [6:0] seg_rect(input logic [4:0] r, input logic [4:0] c);
      return {in_box(r, c,  2,  4,  8, 23),
              in_box(r, c,  2, 12, 24, 27),
              in_box(r, c, 11, 21, 24, 27),
              in_box(r, c, 19, 21,  8, 23),
              in_box(r, c, 11, 21,  4,  7),
              in_box(r, c,  2, 12,  4,  7),
              in_box(r, c, 11, 12,  8, 23)};
   endfunction

   // Segment lookup against the committed digit under this pixel
   always_comb begin
      lit = s1_hit && !blank[s1_k] && (|(seg_enc(disp[s1_k]) & seg_rect(s1_row, s1_col)));
   end

   // Pixel stage 2: registered pixel outputs
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         pixel_on    <= 1'b0;
         pixel_color <= COLOR_W'(BG_COLOR);
      end else begin
         pixel_on    <= s1_hit;
         pixel_color <= lit ? COLOR_W'(FG_COLOR) : COLOR_W'(BG_COLOR);
      end
   end

endmodule

// File: tb/tb_digit_score_renderer.sv
// Randomised bench for digit_score_renderer with a decimal-arithmetic reference model.
module tb_digit_score_renderer;

   localparam int N     = 4;
   localparam int PITCH = 32;
   localparam int OX    = 0;
   localparam int OY    = 0;
   localparam int FG    = 430;
   localparam int BG    = 391;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [13:0] value;
   logic        value_valid;
   logic        frame_start;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        rdy0, rdy1, on0, on1;
   logic [9:0]  col0, col1;

   int checks = 0;
   int passed = 0;

   always #5 Clk = ~Clk;

   digit_score_renderer u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .value(value), .value_valid(value_valid),
      .value_ready(rdy0), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .pixel_on(on0), .pixel_color(col0));

   digit_score_renderer #(.LEAD_BLANK(0), .FRAME_SYNC(0)) u_dut_nb (
      .Clk(Clk), .Reset_n(Reset_n), .value(value), .value_valid(value_valid),
      .value_ready(rdy1), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .pixel_on(on1), .pixel_color(col1));

   // Glyph description in segment letters and rectangle bounds (a..g)
   string enc [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                       "abc", "abcdefg", "abcdfg"};
   string seg_names = "abcdefg";
   int    r_lo [7] = '{2, 2, 11, 19, 11, 2, 11};
   int    r_hi [7] = '{4, 12, 21, 21, 21, 12, 12};
   int    c_lo [7] = '{8, 24, 24, 8, 4, 4, 8};
   int    c_hi [7] = '{23, 27, 27, 23, 7, 7, 23};
   int    lb   [2] = '{1, 0};
   int    fs   [2] = '{1, 0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit has_seg(input string e, input byte ch);
      for (int i = 0; i < e.len(); i++) if (e[i] == ch) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void render(input int x, input int y, input int val, input int lbk,
                                  output int on, output int col);
      int cx, k, c, r, d, p;
      on  = 0;
      col = BG;
      if (x < OX || y < OY) return;
      cx = x - OX;
      k  = cx / PITCH;
      c  = cx % PITCH;
      r  = y - OY;
      if (k >= N || c >= 32 || r >= 24) return;
      on = 1;
      p  = 1;
      for (int i = 0; i < N - 1 - k; i++) p = p * 10;
      d = (val / p) % 10;
      if (lbk != 0 && k < N - 1 && val < p) return;
      for (int s = 0; s < 7; s++)
         if (has_seg(enc[d], seg_names[s]) && r >= r_lo[s] && r <= r_hi[s] &&
             c >= c_lo[s] && c <= c_hi[s]) col = FG;
   endfunction

   // Reference model: busy phases, displayed value and one pipeline stage of coordinates
   int m_idle [2], m_conv [2], m_wait [2], m_commit [2], m_latch [2], m_disp [2];
   int exp_on [2], exp_col [2];
   bit s1v;
   int s1x, s1y;

   always @(posedge Clk) begin
      int act_rdy [2], act_on [2], act_col [2];
      if (!Reset_n) begin
         for (int m = 0; m < 2; m++) begin
            m_idle[m] = 1; m_conv[m] = 0; m_wait[m] = 0; m_commit[m] = 0;
            m_disp[m] = 0; exp_on[m] = 0; exp_col[m] = BG;
         end
         s1v = 0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (s1v) render(s1x, s1y, m_disp[m], lb[m], exp_on[m], exp_col[m]);
            else begin exp_on[m] = 0; exp_col[m] = BG; end
         end
         s1v = 1; s1x = int'(DrawX); s1y = int'(DrawY);
         for (int m = 0; m < 2; m++) begin
            if (m_commit[m] != 0) begin
               m_disp[m] = m_latch[m]; m_commit[m] = 0; m_idle[m] = 1;
            end else if (m_wait[m] != 0) begin
               if (frame_start) begin m_wait[m] = 0; m_commit[m] = 1; end
            end else if (m_conv[m] > 0) begin
               m_conv[m]--;
               if (m_conv[m] == 0) begin
                  if (fs[m] != 0) m_wait[m] = 1; else m_commit[m] = 1;
               end
            end else if (m_idle[m] != 0 && value_valid) begin
               m_latch[m] = (int'(value) > 9999) ? 9999 : int'(value);
               m_idle[m]  = 0;
               m_conv[m]  = 14;
            end
         end
      end
      #1;
      act_rdy[0] = int'(rdy0); act_on[0] = int'(on0); act_col[0] = int'(col0);
      act_rdy[1] = int'(rdy1); act_on[1] = int'(on1); act_col[1] = int'(col1);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("ready[%0d]", m), act_rdy[m], m_idle[m]);
         chk($sformatf("pixel_on[%0d]", m), act_on[m], exp_on[m]);
         chk($sformatf("pixel_color[%0d]", m), act_col[m], exp_col[m]);
      end
   end

   // Literal pixel expectation: colour for both instances, pixel_on for the first
   task automatic pix(input int x, input int y, input int on_e, input int c0_e,
                      input int c1_e, input string name);
      @(negedge Clk);
      DrawX = 10'(x); DrawY = 10'(y);
      @(posedge Clk); @(posedge Clk); #1;
      chk({name, "_on"}, int'(on0), on_e);
      chk({name, "_col0"}, int'(col0), c0_e);
      chk({name, "_col1"}, int'(col1), c1_e);
   endtask

   task automatic load(input int v);
      @(negedge Clk);
      value = 14'(v); value_valid = 1'b1;
      @(negedge Clk);
      value_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge Clk); frame_start = 1'b1;
      @(negedge Clk); frame_start = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic load_commit(input int v);
      load(v);
      repeat (16) @(negedge Clk);
      pulse_frame();
   endtask

   initial begin
      Reset_n = 1'b0; value = '0; value_valid = 1'b0; frame_start = 1'b0;
      DrawX = '0; DrawY = '0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      pix(100, 3, 1, 430, 430, "rst_d3");
      pix(10, 3, 1, 391, 430, "rst_d0");

      // 1234 with a competing offer of 77 during conversion
      load(1234);
      value = 14'd77; value_valid = 1'b1;
      repeat (3) @(negedge Clk);
      value_valid = 1'b0;
      repeat (14) @(negedge Clk);
      chk("ready_wait_frame", int'(rdy0), 0);
      pix(44, 3, 1, 391, 430, "pre_commit_d1");
      pulse_frame();
      chk("ready_after_commit", int'(rdy0), 1);
      pix(10, 3, 1, 391, 391, "d0_1234");
      pix(44, 3, 1, 430, 430, "d1_1234");

      load_commit(77);
      pix(44, 3, 1, 391, 430, "d1_77");
      pix(76, 3, 1, 430, 430, "d2_77");

      load_commit(12345);
      pix(10, 3, 1, 430, 430, "sat_d0");

      load_commit(0);
      pix(108, 3, 1, 430, 430, "zero_d3");
      pix(10, 3, 1, 391, 430, "zero_d0");

      // Reset during the seventh conversion cycle
      load_commit(5678);
      load(1234);
      repeat (6) @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      chk("ready_after_abort", int'(rdy0), 1);
      pix(44, 3, 1, 391, 430, "abort_d1");
      pix(200, 3, 0, 391, 391, "miss_x");
      pix(10, 30, 0, 391, 391, "miss_y");

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge Clk);
         Reset_n     = ($urandom % 700) != 0;
         value_valid = ($urandom % 4) == 0;
         case ($urandom % 4)
            0:       value = 14'($urandom);
            1:       value = 14'($urandom % 100);
            default: value = 14'($urandom % 10000);
         endcase
         frame_start = ($urandom % 25) == 0;
         DrawX       = 10'($urandom % 160);
         DrawY       = 10'($urandom % 30);
      end

      // Row sweeps across the whole line
      @(negedge Clk);
      Reset_n = 1'b1; value_valid = 1'b0; frame_start = 1'b0;
      for (int y = 0; y < 26; y += 11) begin
         for (int x = 0; x < 1024; x++) begin
            @(negedge Clk);
            DrawX = 10'(x); DrawY = 10'(y);
         end
      end
      repeat (3) @(negedge Clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
